// File: rtl/bus_mem_responder_pkg.sv
// Shared bus map for bus_mem_responder: IO register offsets, STATUS bit layout,
// address region encoding and a saturating counter helper.
package bus_mem_responder_pkg;

  localparam int unsigned OFS_OUT_DATA = 0;
  localparam int unsigned OFS_STATUS   = 1;

  localparam int unsigned ST_EMPTY_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_COUNT_LSB = 2;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_OUT_DATA,
    RGN_STATUS,
    RGN_UNMAPPED
  } region_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/bus_mem_responder_out_fifo.sv
// out_fifo: synchronous output FIFO with a registered head word (0 when empty).
// Synchronous active-low reset; a push into a full FIFO is accepted only alongside a pop.
module out_fifo #(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          valid_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          drop_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic          do_pop, do_push;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    drop_o   = push_i & ~do_push;
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head_d   = '0;
    if (count_d != '0) begin
      // Queue drained by this pop (or was empty): the new head is the word being pushed.
      if (count_q == (AW+1)'(do_pop)) head_d = push_data_i;
      else                            head_d = mem_q[rd_ptr_d];
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = ~empty_o;
  assign count_o = count_q;

endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: CPU memory-bus target with word RAM, output FIFO port and sticky errors.
// Define BUS_RESP_STATS_EN to add saturating accepted-read/write counters (rd_cnt, wr_cnt).
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 20,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    MEM_AW     = 10,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 20'hFFFF0,
  parameter int                    FIFO_AW    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  fifo_overflow,
  output logic                  bus_err
`ifdef BUS_RESP_STATS_EN
  ,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           wr_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = IO_BASE + ADDR_WIDTH'(OFS_STATUS);

  logic [DATA_WIDTH-1:0] ram_q [2**MEM_AW];
  logic [MEM_AW-1:0]     ram_idx;
  region_e               region;
  logic                  rd_en, wr_en, conflict;
  logic [DATA_WIDTH-1:0] rdata, status_word;
  logic                  push;
  logic                  err_q, err_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_valid, fifo_full, fifo_empty, fifo_drop;
  logic [FIFO_AW:0]      fifo_count;

  assign ram_idx  = bus_addr[MEM_AW-1:0];
  assign conflict = mem_read & mem_write;
  assign rd_en    = mem_read & ~mem_write;
  assign wr_en    = mem_write & ~mem_read;

  always_comb begin
    region = RGN_UNMAPPED;
    if (bus_addr[ADDR_WIDTH-1:MEM_AW] == '0) region = RGN_RAM;
    else if (bus_addr == IO_BASE)            region = RGN_OUT_DATA;
    else if (bus_addr == STATUS_ADDR)        region = RGN_STATUS;
  end

  always_comb begin
    status_word                                 = '0;
    status_word[ST_EMPTY_BIT]                   = fifo_empty;
    status_word[ST_FULL_BIT]                    = fifo_full;
    status_word[ST_COUNT_LSB +: FIFO_AW+1]      = fifo_count;
    rdata = '0;
    unique case (region)
      RGN_RAM:      rdata = ram_q[ram_idx];
      RGN_OUT_DATA: rdata = fifo_head;
      RGN_STATUS:   rdata = status_word;
      default:      rdata = '0;
    endcase
  end

  // Zero-wait read: the bus is driven only while a read alone is strobed.
  assign bus_data = rd_en ? rdata : 'z;

  assign push = wr_en & (region == RGN_OUT_DATA);

  always_comb begin
    err_d = err_q | conflict
          | (rd_en & (region == RGN_UNMAPPED))
          | (wr_en & ((region == RGN_UNMAPPED) | (region == RGN_STATUS)));
    ovf_d = ovf_q | fifo_drop;
  end

  always_ff @(posedge clk) begin
    if (wr_en && (region == RGN_RAM)) ram_q[ram_idx] <= bus_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  out_fifo #(
    .DW (DATA_WIDTH),
    .AW (FIFO_AW)
  ) u_out_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (bus_data),
    .pop_i       (out_ready),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .drop_o      (fifo_drop)
  );

  assign out_data      = fifo_head;
  assign out_valid     = fifo_valid;
  assign fifo_overflow = ovf_q;
  assign bus_err       = err_q;

`ifdef BUS_RESP_STATS_EN
  logic        rd_ok, wr_ok;
  logic [15:0] rd_cnt_q, wr_cnt_q;

  // Writes to STATUS are errors, so only RAM and OUT_DATA writes count as accepted.
  assign rd_ok = rd_en & (region != RGN_UNMAPPED);
  assign wr_ok = wr_en & ((region == RGN_RAM) | (region == RGN_OUT_DATA));

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= sat_inc16(rd_cnt_q, rd_ok);
      wr_cnt_q <= sat_inc16(wr_cnt_q, wr_ok);
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule
